// File: rtl/tap_delay_pkg.sv
// Shared types and helpers for the tapped delay line: fill-state encoding and tap-select clamp.
package tap_delay_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } fill_state_e;

    // Delay 0 behaves as 1; anything beyond the storage depth reads the oldest entry.
    function automatic int unsigned clamp_dly(int unsigned dly, int unsigned depth);
        if (dly == 32'd0) begin
            return 32'd1;
        end
        if (dly > depth) begin
            return depth;
        end
        return dly;
    endfunction

endpackage

// File: rtl/tap_delay_line_tap_mux.sv
// One output tap: clamped select into the shift register, history-valid compare and change pulse.
module tap_mux
    import tap_delay_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr_i,
    input  logic [DEPTH-1:0][WIDTH-1:0] sr_i,
    input  logic [DW-1:0]               fill_i,
    input  logic [DW-1:0]               dly_i,
    output logic [WIDTH-1:0]            dout_o,
    output logic                        vld_o,
    output logic                        chg_o
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]    eff;
    logic [IW-1:0]    sel;
    logic [WIDTH-1:0] prev_q;
    logic             chg_q, chg_d;

    // Select is combinational off registered history, so a new dly takes effect immediately.
    always_comb begin
        eff    = DW'(clamp_dly(32'(dly_i), DEPTH));
        sel    = IW'(eff - DW'(1));
        dout_o = sr_i[sel];
        vld_o  = (fill_i >= eff);
        chg_d  = vld_o && (dout_o != prev_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            prev_q <= '0;
            chg_q  <= 1'b0;
        end else begin
            prev_q <= dout_o;
            chg_q  <= chg_d;
        end
    end

    assign chg_o = chg_q;

endmodule

// File: rtl/tap_delay_line.sv
// Cycle-granular transport delay with two independently selected taps.
// Holds the shift register, fill counter and fill state; taps live in tap_mux.
module tap_delay_line
    import tap_delay_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic [DW-1:0]    dly_a,
    input  logic [DW-1:0]    dly_b,
    output logic [WIDTH-1:0] dout_a,
    output logic [WIDTH-1:0] dout_b,
    output logic             vld_a,
    output logic             vld_b,
    output logic             chg_a,
    output logic             chg_b
);

    logic [DEPTH-1:0][WIDTH-1:0] sr_q, sr_d;
    logic [DW-1:0]               fill_q, fill_d;
    fill_state_e                 state_q, state_d;

    always_comb begin
        sr_d    = sr_q;
        fill_d  = fill_q;
        state_d = state_q;
        if (flush) begin
            sr_d    = '0;
            fill_d  = '0;
            state_d = EMPTY;
        end else if (en) begin
            sr_d = {sr_q[DEPTH-2:0], din};
            if (fill_q != DW'(DEPTH)) begin
                fill_d = fill_q + DW'(1);
            end
            case (state_q)
                EMPTY:   state_d = FILLING;
                FILLING: state_d = (fill_d == DW'(DEPTH)) ? FULL : FILLING;
                FULL:    state_d = FULL;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q    <= '0;
            fill_q  <= '0;
            state_q <= EMPTY;
        end else begin
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            state_q <= state_d;
        end
    end

    tap_mux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_tap_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (flush),
        .sr_i   (sr_q),
        .fill_i (fill_q),
        .dly_i  (dly_a),
        .dout_o (dout_a),
        .vld_o  (vld_a),
        .chg_o  (chg_a)
    );

    tap_mux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_tap_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (flush),
        .sr_i   (sr_q),
        .fill_i (fill_q),
        .dly_i  (dly_b),
        .dout_o (dout_b),
        .vld_o  (vld_b),
        .chg_o  (chg_b)
    );

endmodule

// File: tb/tb_tap_delay_line.sv
// Self-checking bench for tap_delay_line against a queue-based history model.
module tb_tap_delay_line;
    import tap_delay_pkg::*;

    localparam int WIDTH = 2;
    localparam int DEPTH = 16;
    localparam int DW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n, en, flush;
    logic [WIDTH-1:0] din;
    logic [DW-1:0]    dly_a, dly_b;
    logic [WIDTH-1:0] dout_a, dout_b;
    logic             vld_a, vld_b, chg_a, chg_b;
    logic [7:0]       act;

    int checks = 0;
    int errors = 0;

    // Model: captured samples since last clear, oldest first, trimmed to DEPTH.
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] m_prev_a, m_prev_b;
    logic             m_chg_a, m_chg_b;

    tap_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .flush  (flush),
        .din    (din),
        .dly_a  (dly_a),
        .dly_b  (dly_b),
        .dout_a (dout_a),
        .dout_b (dout_b),
        .vld_a  (vld_a),
        .vld_b  (vld_b),
        .chg_a  (chg_a),
        .chg_b  (chg_b)
    );

    always #5 clk = ~clk;

    assign act = {dout_a, dout_b, vld_a, vld_b, chg_a, chg_b};

    function automatic int m_eff(input logic [DW-1:0] d);
        int v;
        v = int'(d);
        if (v < 1) v = 1;
        if (v > DEPTH) v = DEPTH;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] m_dout(input logic [DW-1:0] d);
        int e;
        e = m_eff(d);
        if (hist.size() >= e) return hist[hist.size() - e];
        return '0;
    endfunction

    function automatic logic m_vld(input logic [DW-1:0] d);
        return hist.size() >= m_eff(d);
    endfunction

    function automatic logic [7:0] exp_vec();
        return {m_dout(dly_a), m_dout(dly_b), m_vld(dly_a), m_vld(dly_b), m_chg_a, m_chg_b};
    endfunction

    task automatic tick(input logic r, input logic e, input logic f, input logic [WIDTH-1:0] d);
        logic na, nb;
        rst_n = r;
        en    = e;
        flush = f;
        din   = d;
        na = m_vld(dly_a) && (m_dout(dly_a) != m_prev_a);
        nb = m_vld(dly_b) && (m_dout(dly_b) != m_prev_b);
        @(posedge clk);
        if (!r || f) begin
            hist.delete();
            m_prev_a = '0;
            m_prev_b = '0;
            m_chg_a  = 1'b0;
            m_chg_b  = 1'b0;
        end else begin
            m_prev_a = m_dout(dly_a);
            m_prev_b = m_dout(dly_b);
            m_chg_a  = na;
            m_chg_b  = nb;
            if (e) begin
                hist.push_back(d);
                if (hist.size() > DEPTH) void'(hist.pop_front());
            end
        end
        #1;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        dly_a = 5'd3;
        dly_b = 5'd1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'(i % 2), 1'(i / 2), 2'(i));
            checks++;
            if (act !== 8'h00 || act !== exp_vec()) begin
                errors++;
                $display("FAIL reset i=%0d got=%b want=%b", i, act, exp_vec());
            end
            checks++;
            if (dut.state_q !== EMPTY) begin
                errors++;
                $display("FAIL reset_state got=%0d want=%0d", dut.state_q, EMPTY);
            end
        end
    endtask

    task automatic test_basic();
        int pulses = 0;
        do_reset();
        dly_a = 5'd3;
        dly_b = 5'd1;
        for (int i = 1; i <= 7; i++) begin
            tick(1'b1, 1'b1, 1'b0, (i == 1) ? 2'b01 : 2'b00);
            if (chg_a === 1'b1) pulses++;
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL basic i=%0d got=%b want=%b", i, act, exp_vec());
            end
            checks++;
            if ((i == 2 && (vld_a !== 1'b0 || dout_a !== 2'b00)) ||
                (i == 3 && (vld_a !== 1'b1 || dout_a !== 2'b01 || chg_a !== 1'b0))) begin
                errors++;
                $display("FAIL basic_latency i=%0d got vld=%b dout=%b chg=%b", i, vld_a, dout_a,
                         chg_a);
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL basic_pulses got=%0d want=2", pulses);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        dly_a = 5'd0;
        dly_b = 5'd20;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)));
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL clamp i=%0d got=%b want=%b", i, act, exp_vec());
            end
            checks++;
            if (vld_a !== 1'b1 || (i == 15 && vld_b !== 1'b0) || (i == 16 && vld_b !== 1'b1)) begin
                errors++;
                $display("FAIL clamp_vld i=%0d got a=%b b=%b", i, vld_a, vld_b);
            end
        end
    endtask

    task automatic test_enable_toggle();
        logic [WIDTH-1:0] d;
        do_reset();
        dly_a = 5'd2;
        dly_b = 5'd1;
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) begin
                d = 2'($urandom_range(0, 2));
                if (d == 2'b10) d = 2'b11;
            end else begin
                d = 2'b10;
            end
            tick(1'b1, 1'(i % 2 == 0), 1'b0, d);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL en_toggle i=%0d got=%b want=%b", i, act, exp_vec());
            end
            checks++;
            if (dout_a === 2'b10 || dout_b === 2'b10) begin
                errors++;
                $display("FAIL en_toggle_leak i=%0d got a=%b b=%b want not 10", i, dout_a, dout_b);
            end
        end
    endtask

    task automatic test_flush_full();
        do_reset();
        dly_a = 5'd16;
        dly_b = 5'd4;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)));
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL flush_fill i=%0d got=%b want=%b", i, act, exp_vec());
            end
        end
        checks++;
        if (dut.state_q !== FULL) begin
            errors++;
            $display("FAIL flush_prestate got=%0d want=%0d", dut.state_q, FULL);
        end
        tick(1'b1, 1'b1, 1'b1, 2'b11);
        checks++;
        if (act !== 8'h00 || act !== exp_vec() || dut.state_q !== EMPTY) begin
            errors++;
            $display("FAIL flush got=%b state=%0d want=00000000 state=%0d", act, dut.state_q,
                     EMPTY);
        end
        tick(1'b1, 1'b0, 1'b0, 2'b01);
        checks++;
        if (act !== 8'h00) begin
            errors++;
            $display("FAIL flush_after got=%b want=00000000", act);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        dly_a = 5'd3;
        dly_b = 5'd7;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 2'($urandom_range(1, 3)));
        checks++;
        if (dut.state_q !== FILLING || act !== exp_vec()) begin
            errors++;
            $display("FAIL midfill state=%0d got=%b want=%b", dut.state_q, act, exp_vec());
        end
        tick(1'b0, 1'b1, 1'b0, 2'b11);
        checks++;
        if (act !== 8'h00) begin
            errors++;
            $display("FAIL midreset got=%b want=00000000", act);
        end
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)));
            checks++;
            if (act !== exp_vec() || (i == 2 && vld_a !== 1'b0) || (i == 3 && vld_a !== 1'b1) ||
                (i == 6 && vld_b !== 1'b0) || (i == 7 && vld_b !== 1'b1)) begin
                errors++;
                $display("FAIL refill i=%0d got=%b want=%b", i, act, exp_vec());
            end
        end
    endtask

    task automatic test_tap_switch();
        logic [WIDTH-1:0] old_v, new_v;
        do_reset();
        dly_a = 5'd1;
        dly_b = 5'd4;
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)));
        tick(1'b1, 1'b0, 1'b0, 2'b00);
        old_v = hist[hist.size() - 4];
        new_v = hist[hist.size() - 2];
        dly_b = 5'd2;
        #1;
        checks++;
        if (act !== exp_vec() || dout_b !== new_v || vld_b !== 1'b1) begin
            errors++;
            $display("FAIL switch got=%b want=%b dout_b want=%b", act, exp_vec(), new_v);
        end
        tick(1'b1, 1'b0, 1'b0, 2'b00);
        checks++;
        if (act !== exp_vec() || chg_b !== (old_v != new_v)) begin
            errors++;
            $display("FAIL switch_chg got=%b want=%b chg_b want=%b", act, exp_vec(),
                     (old_v != new_v));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 8 == 0) begin
                dly_a = 5'($urandom_range(0, 31));
                dly_b = 5'($urandom_range(0, 31));
            end
            tick(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 29) == 0), 2'($urandom_range(0, 3)));
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL random i=%0d dly=%0d/%0d got=%b want=%b", i, dly_a, dly_b, act,
                         exp_vec());
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        flush    = 1'b0;
        din      = '0;
        dly_a    = '0;
        dly_b    = '0;
        m_prev_a = '0;
        m_prev_b = '0;
        m_chg_a  = 1'b0;
        m_chg_b  = 1'b0;
        test_reset();
        test_basic();
        test_clamp();
        test_enable_toggle();
        test_flush_full();
        test_reset_mid();
        test_tap_switch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
